// File: rtl/tristate_bus_ctrl.sv
// Multi-channel single-wire bus controller: timed host start pulse, then edge timestamping.
// Optional GLITCH_FILTER_EN macro adds a FILTER_CYCLES-sample stability filter on the input.
module tristate_bus_ctrl #(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned START_LOW_CYCLES = 900000,
  parameter int unsigned TIMEOUT_CYCLES   = 10000,
  parameter int unsigned CNT_W            = 20,
  parameter int unsigned FILTER_CYCLES    = 4,
  localparam int unsigned CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  inout  wire  [CHANNELS-1:0] port,
  input  logic [CH_W-1:0]     ch_sel,
  input  logic                start,
  output logic                busy,
  output logic                edge_valid,
  output logic                edge_level,
  output logic [CNT_W-1:0]    edge_width,
  output logic [7:0]          edge_count,
  output logic                done
);

  localparam int unsigned LowW = (START_LOW_CYCLES > 1) ? $clog2(START_LOW_CYCLES) : 1;
  localparam logic [LowW-1:0] LowLast = LowW'(START_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  localparam int unsigned FiltW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
`ifdef GLITCH_FILTER_EN
  localparam int unsigned FiltLen = FILTER_CYCLES;
`else
  localparam int unsigned FiltLen = 1;
`endif
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FiltLen - 1);

  typedef enum logic [1:0] {StIdle, StDriveLow, StRelease} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [LowW-1:0]   low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [FiltW-1:0]  fcnt_q, fcnt_d;
  logic              level_q, level_d;
  logic              sync1_q, sync2_q;
  logic              edge_valid_q, edge_valid_d;
  logic              edge_level_q, edge_level_d;
  logic [CNT_W-1:0]  edge_width_q, edge_width_d;
  logic [7:0]        edge_count_q, edge_count_d;
  logic              done_q, done_d;
  logic              pin_in;
  logic              ch_sel_ok;
  logic              edge_det;

  // Only ever pull low; the external pull-up supplies the high level.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_pad
    assign port[i] = (state_q == StDriveLow && ch_q == CH_W'(i)) ? 1'b0 : 1'bz;
  end

  assign pin_in    = port[ch_q];
  assign ch_sel_ok = (32'(ch_sel) < CHANNELS);
  assign busy      = (state_q != StIdle);

  // Synchronizer is held at the idle level while we drive, so our own low pulse never
  // reaches the edge detector.
  always_ff @(posedge clock) begin
    if (reset || state_q == StDriveLow) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
    end
  end

  assign edge_det = (state_q == StRelease) && (sync2_q != level_q) && (fcnt_q == FiltLast);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    low_cnt_d    = low_cnt_q;
    cnt_d        = cnt_q;
    level_d      = level_q;
    fcnt_d       = fcnt_q;
    edge_valid_d = 1'b0;
    edge_level_d = edge_level_q;
    edge_width_d = edge_width_q;
    edge_count_d = edge_count_q;
    done_d       = 1'b0;

    // Counts consecutive samples that disagree with the accepted level.
    if (state_q != StRelease || sync2_q == level_q || edge_det) begin
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start && ch_sel_ok) begin
          state_d      = StDriveLow;
          ch_d         = ch_sel;
          low_cnt_d    = '0;
          edge_count_d = '0;
        end
      end
      StDriveLow: begin
        if (low_cnt_q == LowLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          level_d = 1'b1;
        end else begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end
      StRelease: begin
        // An edge takes priority over a coincident timeout.
        if (edge_det) begin
          edge_valid_d = 1'b1;
          edge_level_d = sync2_q;
          edge_width_d = cnt_q;
          level_d      = sync2_q;
          cnt_d        = CNT_W'(1);
          if (edge_count_q != 8'hff) begin
            edge_count_d = edge_count_q + 8'd1;
          end
        end else if (cnt_inc == TimeoutVal) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      ch_q         <= '0;
      low_cnt_q    <= '0;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      level_q      <= 1'b1;
      edge_valid_q <= 1'b0;
      edge_level_q <= 1'b0;
      edge_width_q <= '0;
      edge_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      low_cnt_q    <= low_cnt_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      level_q      <= level_d;
      edge_valid_q <= edge_valid_d;
      edge_level_q <= edge_level_d;
      edge_width_q <= edge_width_d;
      edge_count_q <= edge_count_d;
      done_q       <= done_d;
    end
  end

  assign edge_valid = edge_valid_q;
  assign edge_level = edge_level_q;
  assign edge_width = edge_width_q;
  assign edge_count = edge_count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Directed bench for tristate_bus_ctrl with a scoreboard of expected edges.
// Three channels so that an out-of-range ch_sel is representable.
module tb_tristate_bus_ctrl;

  localparam int unsigned CH   = 3;
  localparam int unsigned LOW  = 10;
  localparam int unsigned TO   = 50;
  localparam int unsigned W    = 8;
  localparam int unsigned FILT = 4;
`ifdef GLITCH_FILTER_EN
  localparam int XL = FILT - 1;
`else
  localparam int XL = 0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    ch_sel;
  wire  [CH-1:0] port;
  logic          busy, edge_valid, edge_level, done;
  logic [W-1:0]  edge_width;
  logic [7:0]    edge_count;
  logic [CH-1:0] dev_low;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  typedef struct packed {
    logic         level;
    logic [W-1:0] width;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  for (genvar i = 0; i < CH; i++) begin : g_bus
    pullup (port[i]);
    assign port[i] = dev_low[i] ? 1'b0 : 1'bz;
  end

  tristate_bus_ctrl #(
    .CHANNELS        (CH),
    .START_LOW_CYCLES(LOW),
    .TIMEOUT_CYCLES  (TO),
    .CNT_W           (W),
    .FILTER_CYCLES   (FILT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .port      (port),
    .ch_sel    (ch_sel),
    .start     (start),
    .busy      (busy),
    .edge_valid(edge_valid),
    .edge_level(edge_level),
    .edge_width(edge_width),
    .edge_count(edge_count),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_edge(input logic lvl, input int wdt);
    exp_q.push_back({lvl, W'(wdt)});
  endtask

  // Scoreboard side: every edge pulse must match the oldest expected edge.
  always @(negedge clock) begin
    if (edge_valid === 1'b1) begin
      chk("edge_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("edge_level", 32'(edge_level), 32'(e.level));
        chk("edge_width", 32'(edge_width), 32'(e.width));
      end
    end
    if (done === 1'b1) n_done++;
  end

  initial begin
    int got_done;
    reset   = 1'b1;
    start   = 1'b0;
    ch_sel  = 2'd0;
    dev_low = '0;
    step(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_edge_valid", 32'(edge_valid), 0);
    chk("rst_edge_level", 32'(edge_level), 0);
    chk("rst_edge_width", 32'(edge_width), 0);
    chk("rst_edge_count", 32'(edge_count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_port", 32'(port), 7);
    reset = 1'b0;

    // Out-of-range channel is ignored.
    ch_sel = 2'd3;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    chk("badch_busy", 32'(busy), 0);
    chk("badch_port", 32'(port), 7);
    step(3);
    chk("badch_busy_later", 32'(busy), 0);

    // Transaction 1: channel 1, device answers with a 20-cycle low.
    ch_sel = 2'd1;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    chk("tx1_busy", 32'(busy), 1);
    for (int k = 1; k <= 10; k++) begin
      chk("tx1_drive_port", 32'(port), 5);
      if (k == 3) begin
        start  = 1'b1;
        ch_sel = 2'd0;
      end
      if (k == 4) start = 1'b0;
      if (k < 10) step(1);
    end
    step(1);
    chk("tx1_release_port", 32'(port), 7);
    chk("tx1_release_busy", 32'(busy), 1);
    dev_low[1] = 1'b1;
    expect_edge(1'b0, 2 + XL);
    step(2 + XL);
    chk("tx1_latency_pre", 32'(edge_valid), 0);
    step(1);
    chk("tx1_latency_hit", 32'(edge_valid), 1);
    step(17 - XL);
    dev_low[1] = 1'b0;
    expect_edge(1'b1, 20);
    step(51 + XL);
    chk("tx1_done_pre", 32'(done), 0);
    chk("tx1_busy_pre", 32'(busy), 1);
    step(1);
    chk("tx1_done", 32'(done), 1);
    chk("tx1_busy_done", 32'(busy), 0);
    chk("tx1_count", 32'(edge_count), 2);
    step(1);
    chk("tx1_done_pulse", 32'(done), 0);
    chk("tx1_count_hold", 32'(edge_count), 2);
    chk("tx1_n_done", 32'(n_done), 1);

    // Transaction 2: channel 0, silent bus -> timeout.
    ch_sel = 2'd0;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    chk("tx2_count_clr", 32'(edge_count), 0);
    chk("tx2_port_first", 32'(port), 6);
    step(9);
    chk("tx2_port_last", 32'(port), 6);
    step(1);
    chk("tx2_port_rel", 32'(port), 7);
    step(49);
    chk("tx2_done_pre", 32'(done), 0);
    step(1);
    chk("tx2_done", 32'(done), 1);
    chk("tx2_busy", 32'(busy), 0);
    chk("tx2_count", 32'(edge_count), 0);

    // Transaction 3: edge lands on the timeout cycle; the edge must win.
    ch_sel = 2'd1;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    step(57 - XL);
    dev_low[1] = 1'b1;
    expect_edge(1'b0, 49);
    step(5);
    dev_low[1] = 1'b0;
    expect_edge(1'b1, 5);
    step(51 + XL);
    chk("tx3_done_pre", 32'(done), 0);
    chk("tx3_n_done_pre", 32'(n_done), 2);
    step(1);
    chk("tx3_done", 32'(done), 1);
    chk("tx3_count", 32'(edge_count), 2);

    // Transaction 4: reset during the start pulse.
    ch_sel = 2'd1;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    chk("tx4_driving", 32'(port), 5);
    reset = 1'b1;
    step(1);
    chk("tx4_port", 32'(port), 7);
    chk("tx4_busy", 32'(busy), 0);
    chk("tx4_done", 32'(done), 0);
    chk("tx4_edge_valid", 32'(edge_valid), 0);
    chk("tx4_edge_level", 32'(edge_level), 0);
    chk("tx4_edge_width", 32'(edge_width), 0);
    chk("tx4_count", 32'(edge_count), 0);
    reset = 1'b0;
    step(70);
    chk("tx4_no_done", 32'(n_done), 3);
    chk("tx4_idle", 32'(busy), 0);

    // Transaction 5: 2-cycle glitch then a 6-cycle low on channel 0.
    ch_sel = 2'd0;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    step(14);
    dev_low[0] = 1'b1;
`ifndef GLITCH_FILTER_EN
    expect_edge(1'b0, 6);
`endif
    step(2);
    dev_low[0] = 1'b0;
`ifndef GLITCH_FILTER_EN
    expect_edge(1'b1, 2);
`endif
    step(8);
    dev_low[0] = 1'b1;
`ifdef GLITCH_FILTER_EN
    expect_edge(1'b0, 19);
`else
    expect_edge(1'b0, 8);
`endif
    step(6);
    dev_low[0] = 1'b0;
    expect_edge(1'b1, 6);
    got_done = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (done === 1'b1) begin
        got_done = 1;
        break;
      end
    end
    chk("tx5_done_seen", 32'(got_done), 1);
`ifdef GLITCH_FILTER_EN
    chk("tx5_count", 32'(edge_count), 2);
`else
    chk("tx5_count", 32'(edge_count), 4);
`endif
    step(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
